// File: rtl/arp_lookup_ctrl.sv
// ARP lookup controller: resolves an IP to a MAC via the ARP cache, issuing bounded ARP request retries.
// Optional macro ARP_LOOKUP_BCAST_BYPASS_EN answers broadcast IPs with ff:ff:ff:ff:ff:ff without touching the cache.
module arp_lookup_ctrl #(
    parameter int unsigned REQUEST_RETRY_COUNT = 4,
    parameter int unsigned REQUEST_TIMEOUT     = 125000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        lookup_req_valid,
    output logic        lookup_req_ready,
    input  logic [31:0] lookup_req_ip,
    output logic        lookup_resp_valid,
    input  logic        lookup_resp_ready,
    output logic        lookup_resp_error,
    output logic [47:0] lookup_resp_mac,

    output logic        cache_query_valid,
    input  logic        cache_query_ready,
    output logic [31:0] cache_query_ip,
    input  logic        cache_resp_valid,
    output logic        cache_resp_ready,
    input  logic        cache_resp_error,
    input  logic [47:0] cache_resp_mac,

    output logic        arp_req_valid,
    input  logic        arp_req_ready,
    output logic [31:0] arp_req_ip,

    input  logic [31:0] local_ip,
    input  logic [31:0] gateway_ip,
    input  logic [31:0] subnet_mask
);

    // state       | meaning
    // IDLE        | ready for a new lookup
    // CACHE_QUERY | presenting resolve IP to the ARP cache
    // CACHE_WAIT  | waiting for the cache hit/miss result
    // ARP_SEND    | presenting an ARP request to the TX path
    // ARP_WAIT    | timer running before re-querying the cache
    // RESPOND     | presenting the lookup result
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CACHE_QUERY = 3'd1,
        CACHE_WAIT  = 3'd2,
        ARP_SEND    = 3'd3,
        ARP_WAIT    = 3'd4,
        RESPOND     = 3'd5
    } state_t;

    localparam logic [31:0] RETRY_MAX   = 32'(REQUEST_RETRY_COUNT);
    localparam logic [31:0] TIMEOUT_VAL = 32'(REQUEST_TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] ip_q, ip_d;
    logic [31:0] retry_q, retry_d;
    logic [31:0] timer_q, timer_d;
    logic [47:0] mac_q, mac_d;
    logic        err_q, err_d;
    logic        run_q;

    logic        in_subnet;
    logic        req_hs;

    assign in_subnet = ((lookup_req_ip ^ local_ip) & subnet_mask) == 32'd0;
    assign req_hs    = (state_q == IDLE) && run_q && lookup_req_valid;

`ifdef ARP_LOOKUP_BCAST_BYPASS_EN
    logic is_bcast;
    assign is_bcast = (lookup_req_ip == 32'hffff_ffff) ||
                      (in_subnet && ((lookup_req_ip & ~subnet_mask) == ~subnet_mask));
`endif

    // run_q keeps lookup_req_ready low until the first edge after reset release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ip_q    <= 32'd0;
            retry_q <= 32'd0;
            timer_q <= 32'd0;
            mac_q   <= 48'd0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            retry_q <= retry_d;
            timer_q <= timer_d;
            mac_q   <= mac_d;
            err_q   <= err_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ip_d    = ip_q;
        retry_d = retry_q;
        timer_d = timer_q;
        mac_d   = mac_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    ip_d    = in_subnet ? lookup_req_ip : gateway_ip;
                    retry_d = 32'd0;
                    mac_d   = 48'd0;
                    err_d   = 1'b0;
                    state_d = CACHE_QUERY;
`ifdef ARP_LOOKUP_BCAST_BYPASS_EN
                    if (is_bcast) begin
                        mac_d   = 48'hffff_ffff_ffff;
                        state_d = RESPOND;
                    end
`endif
                end
            end
            CACHE_QUERY: begin
                if (cache_query_ready) state_d = CACHE_WAIT;
            end
            CACHE_WAIT: begin
                if (cache_resp_valid) begin
                    if (!cache_resp_error) begin
                        mac_d   = cache_resp_mac;
                        err_d   = 1'b0;
                        state_d = RESPOND;
                    end else if (retry_q < RETRY_MAX) begin
                        state_d = ARP_SEND;
                    end else begin
                        mac_d   = 48'd0;
                        err_d   = 1'b1;
                        state_d = RESPOND;
                    end
                end
            end
            ARP_SEND: begin
                if (arp_req_ready) begin
                    retry_d = retry_q + 32'd1;
                    timer_d = TIMEOUT_VAL;
                    state_d = ARP_WAIT;
                end
            end
            ARP_WAIT: begin
                // a zero timeout load falls straight through to the re-query
                timer_d = (timer_q == 32'd0) ? 32'd0 : timer_q - 32'd1;
                if (timer_q <= 32'd1) state_d = CACHE_QUERY;
            end
            RESPOND: begin
                if (lookup_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lookup_req_ready  = (state_q == IDLE) && run_q;
        cache_query_valid = (state_q == CACHE_QUERY);
        cache_query_ip    = ip_q;
        cache_resp_ready  = (state_q == CACHE_WAIT);
        arp_req_valid     = (state_q == ARP_SEND);
        arp_req_ip        = ip_q;
        lookup_resp_valid = (state_q == RESPOND);
        lookup_resp_error = err_q;
        lookup_resp_mac   = mac_q;
    end

endmodule
